// File: rtl/segre_mem_arbiter.sv
// Main-memory port arbiter between the icache miss path and the dcache miss/writeback
// path: one outstanding lane transaction, round-robin on conflict, one-cycle fill pulse.
module segre_mem_arbiter #(
  parameter int ADDR_SIZE  = 32,
  parameter int LANE_SIZE  = 128,
  parameter int INDEX_SIZE = 2
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  ic_miss_i,
  input  logic [ADDR_SIZE-1:0]  ic_addr_i,
  input  logic                  dc_miss_i,
  input  logic [ADDR_SIZE-1:0]  dc_addr_i,
  input  logic                  dc_dirty_i,
  input  logic [ADDR_SIZE-1:0]  dc_wb_addr_i,
  input  logic [LANE_SIZE-1:0]  dc_wb_data_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_SIZE-1:0]  mem_addr_o,
  output logic [LANE_SIZE-1:0]  mem_wr_data_o,
  input  logic                  mem_ready_i,
  input  logic [LANE_SIZE-1:0]  mem_rd_data_i,
  output logic                  ic_fill_o,
  output logic [INDEX_SIZE-1:0] ic_fill_index_o,
  output logic                  dc_fill_o,
  output logic [INDEX_SIZE-1:0] dc_fill_index_o,
  output logic [LANE_SIZE-1:0]  fill_data_o
);

  localparam int                   LANE_BYTES = LANE_SIZE / 8;
  localparam logic [ADDR_SIZE-1:0] LANE_MASK  = ADDR_SIZE'(LANE_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DC_WB = 3'd1,
    DC_RD = 3'd2,
    IC_RD = 3'd3,
    FILL  = 3'd4
  } state_t;

  function automatic logic [ADDR_SIZE-1:0] lane_align(input logic [ADDR_SIZE-1:0] a);
    return a & ~LANE_MASK;
  endfunction

  state_t                  state_r;
  logic                    last_dc_r;   // 1 = last grant went to the dcache
  logic                    hold_r;      // blocks sampling in the first IDLE cycle after FILL
  logic [ADDR_SIZE-1:0]    dc_rd_addr_r;
  logic [INDEX_SIZE-1:0]   ic_cnt_r;
  logic [INDEX_SIZE-1:0]   dc_cnt_r;
  logic                    mem_req_r;
  logic                    mem_we_r;
  logic [ADDR_SIZE-1:0]    mem_addr_r;
  logic [LANE_SIZE-1:0]    mem_wr_data_r;
  logic                    ic_fill_r;
  logic                    dc_fill_r;
  logic [LANE_SIZE-1:0]    fill_data_r;

  // Transaction sequencer with registered memory and fill outputs.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_r       <= IDLE;
      last_dc_r     <= 1'b0;
      hold_r        <= 1'b0;
      dc_rd_addr_r  <= '0;
      ic_cnt_r      <= '0;
      dc_cnt_r      <= '0;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= '0;
      mem_wr_data_r <= '0;
      ic_fill_r     <= 1'b0;
      dc_fill_r     <= 1'b0;
      fill_data_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hold_r) begin
            hold_r <= 1'b0;
          end else if (ic_miss_i && (!dc_miss_i || last_dc_r)) begin
            state_r       <= IC_RD;
            last_dc_r     <= 1'b0;
            mem_req_r     <= 1'b1;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= lane_align(ic_addr_i);
            mem_wr_data_r <= '0;
          end else if (dc_miss_i) begin
            last_dc_r    <= 1'b1;
            mem_req_r    <= 1'b1;
            dc_rd_addr_r <= lane_align(dc_addr_i);
            if (dc_dirty_i) begin
              state_r       <= DC_WB;
              mem_we_r      <= 1'b1;
              mem_addr_r    <= lane_align(dc_wb_addr_i);
              mem_wr_data_r <= dc_wb_data_i;
            end else begin
              state_r       <= DC_RD;
              mem_we_r      <= 1'b0;
              mem_addr_r    <= lane_align(dc_addr_i);
              mem_wr_data_r <= '0;
            end
          end
        end
        DC_WB: begin
          // Writeback done: keep the request up and switch it to the refill read.
          if (mem_ready_i) begin
            state_r       <= DC_RD;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= dc_rd_addr_r;
            mem_wr_data_r <= '0;
          end
        end
        DC_RD: begin
          if (mem_ready_i) begin
            state_r     <= FILL;
            mem_req_r   <= 1'b0;
            fill_data_r <= mem_rd_data_i;
            dc_fill_r   <= 1'b1;
          end
        end
        IC_RD: begin
          if (mem_ready_i) begin
            state_r     <= FILL;
            mem_req_r   <= 1'b0;
            fill_data_r <= mem_rd_data_i;
            ic_fill_r   <= 1'b1;
          end
        end
        FILL: begin
          state_r   <= IDLE;
          hold_r    <= 1'b1;
          ic_fill_r <= 1'b0;
          dc_fill_r <= 1'b0;
          if (last_dc_r) begin
            dc_cnt_r <= dc_cnt_r + INDEX_SIZE'(1);
          end else begin
            ic_cnt_r <= ic_cnt_r + INDEX_SIZE'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
          ic_fill_r <= 1'b0;
          dc_fill_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o       = mem_req_r;
  assign mem_we_o        = mem_we_r;
  assign mem_addr_o      = mem_addr_r;
  assign mem_wr_data_o   = mem_wr_data_r;
  assign ic_fill_o       = ic_fill_r;
  assign dc_fill_o       = dc_fill_r;
  assign ic_fill_index_o = ic_cnt_r;
  assign dc_fill_index_o = dc_cnt_r;
  assign fill_data_o     = fill_data_r;

endmodule
